elm_layer_ctrl: RTL and testbench

//  Sequencer for one ELM hidden layer of NUM_NEURON neurons sharing the myinput/weight/bias buses.

---
 rtl/elm_layer_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_elm_layer_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elm_layer_ctrl.sv
// ---------------------------------------------------------------------------
// elm_layer_ctrl
//
// Sequencer for one ELM hidden layer of NUM_NEURON neurons that share the
// myinput / weight / bias buses.
//
//   LOAD : streams NUM_WEIGHT weights and then one bias into each neuron in
//          turn. The target neuron is named on config_layer_num /
//          config_neuron_num.
//   RUN  : broadcasts one NUM_WEIGHT-word input vector to every neuron,
//          collects every neuron_outvalid bit, then pulses done.
//
// Handshake: a beat happens on a rising clk edge where valid and ready are
// both 1. ready is a pure function of the current state and never depends
// on valid. The producer holds data stable while valid=1 and ready=0.
// valid=0 is a stall and leaves every counter unchanged.
//
// Ports
//   clk, rst                   clock (rising edge); async reset, active high
//   load_start, run_start      start pulses (load_start wins when both are 1)
//   cfg_data/valid/ready       weight+bias stream (accepted in LOAD states)
//   in_data/valid/ready        input-vector stream (accepted in RUN)
//   myinput, myinputValid      registered broadcast of each input beat
//   weightValue, weightValid   registered copy of each weight beat
//   biasValue, biasValid       registered copy of each bias beat
//   config_layer_num           constant LAYER_NO
//   config_neuron_num          neuron being loaded; all-ones otherwise
//   neuron_outvalid            per-neuron outvalid, bit n = neuron n
//   busy, loaded               status flags
//   done, err                  1-cycle status pulses
//   state_dbg                  current FSM state encoding, for checkers
// ---------------------------------------------------------------------------
module elm_layer_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_WEIGHT = 128,
  parameter int NUM_NEURON = 20,
  parameter int LAYER_NO   = 1,
  parameter int DRAIN_MAX  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    run_start,
  input  logic [DATA_WIDTH-1:0]   cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   myinput,
  output logic                    myinputValid,
  output logic [DATA_WIDTH-1:0]   weightValue,
  output logic                    weightValid,
  output logic [DATA_WIDTH-1:0]   biasValue,
  output logic                    biasValid,
  output logic [2*DATA_WIDTH:0]   config_layer_num,
  output logic [2*DATA_WIDTH:0]   config_neuron_num,
  input  logic [NUM_NEURON-1:0]   neuron_outvalid,
  output logic                    busy,
  output logic                    loaded,
  output logic                    done,
  output logic                    err,
  output logic [2:0]              state_dbg
);

  localparam int CW  = 2*DATA_WIDTH + 1;
  localparam int WCW = $clog2(NUM_WEIGHT + 1);
  localparam int NCW = $clog2(NUM_NEURON + 1);
  localparam int DCW = $clog2(DRAIN_MAX + 1);

  localparam logic [WCW-1:0] W_LAST = WCW'(NUM_WEIGHT - 1);
  localparam logic [NCW-1:0] N_LAST = NCW'(NUM_NEURON - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_B = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [WCW-1:0]        wcnt;   // weight index in LOAD_W, input index in RUN
  logic [NCW-1:0]        nidx;   // neuron being loaded
  logic [DCW-1:0]        dcnt;   // cycles spent in DRAIN
  logic [NUM_NEURON-1:0] seen;   // sticky OR of neuron_outvalid during DRAIN

  logic cfg_beat, in_beat;
  logic last_w, last_n, drain_to, seen_all;
  logic start_load, start_run, bad_run;

  assign cfg_ready = (state == S_LOAD_W) || (state == S_LOAD_B);
  assign in_ready  = (state == S_RUN);
  assign cfg_beat  = cfg_valid && cfg_ready;
  assign in_beat   = in_valid && in_ready;

  assign last_w   = (wcnt == W_LAST);
  assign last_n   = (nidx == N_LAST);
  assign drain_to = (dcnt == D_LAST);
  // Include this cycle's bits so an outvalid arriving now counts immediately.
  assign seen_all = &(seen | neuron_outvalid);

  // Starts are only honoured in IDLE; load_start has priority.
  assign start_load = (state == S_IDLE) && load_start;
  assign start_run  = (state == S_IDLE) && run_start && !load_start && loaded;
  assign bad_run    = (state == S_IDLE) && run_start && !load_start && !loaded;

  assign busy             = (state != S_IDLE);
  assign state_dbg        = state;
  assign config_layer_num = CW'(LAYER_NO);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start_load)     state_nx = S_LOAD_W;
        else if (start_run) state_nx = S_RUN;
      end
      S_LOAD_W: if (cfg_beat && last_w) state_nx = S_LOAD_B;
      S_LOAD_B: if (cfg_beat)           state_nx = last_n ? S_IDLE : S_LOAD_W;
      S_RUN:    if (in_beat && last_w)  state_nx = S_DRAIN;
      S_DRAIN:  if (seen_all || drain_to) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // ------------------------------------------------- counters and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt   <= '0;
      nidx   <= '0;
      dcnt   <= '0;
      seen   <= '0;
      loaded <= 1'b0;
    end else begin
      if (start_load || start_run)
        wcnt <= '0;
      else if ((state == S_LOAD_W && cfg_beat) || in_beat)
        wcnt <= last_w ? '0 : wcnt + 1'b1;

      if (start_load)
        nidx <= '0;
      else if (state == S_LOAD_B && cfg_beat && !last_n)
        nidx <= nidx + 1'b1;

      if (start_run) begin
        dcnt <= '0;
        seen <= '0;
      end else if (state == S_DRAIN) begin
        dcnt <= dcnt + 1'b1;   // leaves DRAIN at D_LAST, so never wraps
        seen <= seen | neuron_outvalid;
      end

      if (start_load)
        loaded <= 1'b0;
      else if (state == S_LOAD_B && cfg_beat && last_n)
        loaded <= 1'b1;
    end
  end

  // ------------------------------------------- neuron-side registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      myinput           <= '0;
      myinputValid      <= 1'b0;
      weightValue       <= '0;
      weightValid       <= 1'b0;
      biasValue         <= '0;
      biasValid         <= 1'b0;
      config_neuron_num <= '1;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      weightValid  <= (state == S_LOAD_W) && cfg_beat;
      biasValid    <= (state == S_LOAD_B) && cfg_beat;
      myinputValid <= in_beat;
      done         <= (state == S_DRAIN) && seen_all;
      err          <= bad_run || ((state == S_DRAIN) && !seen_all && drain_to);

      if (state == S_LOAD_W && cfg_beat) weightValue <= cfg_data;
      if (state == S_LOAD_B && cfg_beat) biasValue   <= cfg_data;
      if (in_beat)                       myinput     <= in_data;

      // Registered from the current nidx, so the address lags nidx by one
      // cycle and stays on the old neuron while its bias valid is shown.
      // The first IDLE cycle after the last bias still shows that neuron.
      if (start_load)
        config_neuron_num <= '0;
      else if (state == S_LOAD_W || state == S_LOAD_B)
        config_neuron_num <= CW'(nidx);
      else
        config_neuron_num <= '1;
    end
  end

endmodule

// File: tb/tb_elm_layer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_elm_layer_ctrl
//
// Self-checking bench for elm_layer_ctrl with a small layer (4 weights,
// 2 neurons, drain limit 8). Neuron-side beats are matched against an
// expected queue that is built from the word index of each stimulus word.
// Drain outcome and timing are predicted from when the last outvalid bit
// arrives.
// ---------------------------------------------------------------------------
module tb_elm_layer_ctrl;

  localparam int DW = 16;
  localparam int NW = 4;
  localparam int NN = 2;
  localparam int LN = 1;
  localparam int DM = 8;
  localparam int CW = 2*DW + 1;
  localparam int EW = 2 + CW + DW;

  localparam logic [CW-1:0] ALL1 = '1;

  // ---------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          load_start, run_start;
  logic [DW-1:0] cfg_data, in_data;
  logic          cfg_valid, cfg_ready, in_valid, in_ready;
  logic [DW-1:0] myinput, weightValue, biasValue;
  logic          myinputValid, weightValid, biasValid;
  logic [CW-1:0] config_layer_num, config_neuron_num;
  logic [NN-1:0] neuron_outvalid;
  logic          busy, loaded, done, err;
  logic [2:0]    state_dbg;

  elm_layer_ctrl #(
    .DATA_WIDTH(DW), .NUM_WEIGHT(NW), .NUM_NEURON(NN),
    .LAYER_NO(LN), .DRAIN_MAX(DM)
  ) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .run_start(run_start),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .myinput(myinput), .myinputValid(myinputValid),
    .weightValue(weightValue), .weightValid(weightValid),
    .biasValue(biasValue), .biasValid(biasValid),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .neuron_outvalid(neuron_outvalid),
    .busy(busy), .loaded(loaded), .done(done), .err(err),
    .state_dbg(state_dbg)
  );

  // ---------------------------------------------------- checking
  int n_cmp = 0;
  int n_bad = 0;
  int n_err_pulse = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------- scoreboard
  // Entry = {kind, neuron address, data}; kind 0 weight, 1 bias, 2 input.
  logic [EW-1:0] exp_q[$];

  task automatic sb_push(input logic [1:0] kind, input logic [CW-1:0] nrn, input logic [DW-1:0] d);
    exp_q.push_back({kind, nrn, d});
  endtask

  task automatic sb_take(input logic [EW-1:0] got);
    logic [EW-1:0] e;
    check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_event", 64'(got), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (weightValid)  sb_take({2'd0, config_neuron_num, weightValue});
      if (biasValid)    sb_take({2'd1, config_neuron_num, biasValue});
      if (myinputValid) sb_take({2'd2, config_neuron_num, myinput});
      if (err)          n_err_pulse++;
    end
  end

  // ---------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_send(input logic [DW-1:0] d, input int gap);
    int b;
    repeat (gap) tick();
    cfg_data  = d;
    cfg_valid = 1'b1;
    b = 0;
    @(negedge clk);
    while (!cfg_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("cfg_ready_wait", 64'(cfg_ready), 64'd1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic in_send(input logic [DW-1:0] d, input int gap);
    int b;
    repeat (gap) tick();
    in_data  = d;
    in_valid = 1'b1;
    b = 0;
    @(negedge clk);
    while (!in_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Full load of every neuron. Word k belongs to neuron k/(NW+1); the last
  // word of each group is that neuron's bias.
  task automatic load_all(input int max_gap, input bit with_run);
    logic [DW-1:0] d;
    int errs_before;
    errs_before = n_err_pulse;
    load_start = 1'b1;
    run_start  = with_run;
    tick();
    load_start = 1'b0;
    run_start  = 1'b0;
    check("load_busy", 64'(busy), 64'd1);
    check("load_clears_loaded", 64'(loaded), 64'd0);
    for (int k = 0; k < NN*(NW+1); k++) begin
      d = DW'($urandom);
      sb_push((k % (NW+1) == NW) ? 2'd1 : 2'd0, CW'(k / (NW+1)), d);
      if (k == 3) begin
        run_start = 1'b1;   // ignored while busy
        tick();
        run_start = 1'b0;
      end
      cfg_send(d, $urandom_range(0, max_gap));
    end
    tick();
    tick();
    check("load_loaded", 64'(loaded), 64'd1);
    check("load_idle", 64'(busy), 64'd0);
    check("load_nrn_idle", 64'(config_neuron_num), 64'(ALL1));
    check("load_sb_drained", 64'(exp_q.size()), 64'd0);
    check("load_no_err", 64'(n_err_pulse), 64'(errs_before));
  endtask

  // One inference: NW input beats, then outvalid bit0 pulses in drain cycle
  // t0 and bit1 in cycle t1. Drain cycle 0 is the first cycle after the last
  // input beat. Reference rule: if both bits arrived before DM cycles
  // elapsed, done shows one cycle after the later one; otherwise err shows
  // in cycle DM.
  task automatic run_case(input int gap_after, input int max_gap, input int t0, input int t1);
    logic [DW-1:0] d;
    int done_at, err_at, nd, ne, last, exp_done, exp_err;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("run_busy", 64'(busy), 64'd1);
    check("run_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < NW; i++) begin
      d = DW'($urandom);
      sb_push(2'd2, ALL1, d);
      in_send(d, (i == gap_after) ? 3 : $urandom_range(0, max_gap));
    end
    done_at = -1; err_at = -1; nd = 0; ne = 0;
    for (int c = 0; c < DM + 3; c++) begin
      neuron_outvalid = {c == t1, c == t0};
      in_valid  = 1'b1;               // must be ignored outside RUN
      in_data   = DW'($urandom);
      cfg_valid = 1'b1;               // must be ignored outside LOAD
      cfg_data  = DW'($urandom);
      @(negedge clk);
      if (done) begin nd++; if (done_at < 0) done_at = c; end
      if (err)  begin ne++; if (err_at  < 0) err_at  = c; end
      tick();
    end
    neuron_outvalid = '0;
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    last = (t0 > t1) ? t0 : t1;
    if (last < DM) begin exp_done = last + 1; exp_err = -1; end
    else           begin exp_done = -1;       exp_err = DM; end
    check("drain_done_cycle", 64'(done_at), 64'(exp_done));
    check("drain_err_cycle", 64'(err_at), 64'(exp_err));
    check("drain_done_count", 64'(nd), 64'(exp_done >= 0));
    check("drain_err_count", 64'(ne), 64'(exp_err >= 0));
    check("run_end_idle", 64'(busy), 64'd0);
    check("run_keeps_loaded", 64'(loaded), 64'd1);
    check("run_sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_loaded"}, 64'(loaded), 64'd0);
    check({tag, "_valids"}, 64'({weightValid, biasValid, myinputValid}), 64'd0);
    check({tag, "_readies"}, 64'({cfg_ready, in_ready}), 64'd0);
    check({tag, "_done_err"}, 64'({done, err}), 64'd0);
    check({tag, "_nrn"}, 64'(config_neuron_num), 64'(ALL1));
    check({tag, "_layer"}, 64'(config_layer_num), 64'(LN));
  endtask

  // ---------------------------------------------------- main sequence
  initial begin
    logic [DW-1:0] d;
    rst = 1'b1;
    load_start = 1'b0; run_start = 1'b0;
    cfg_data = '0; cfg_valid = 1'b0;
    in_data = '0;  in_valid = 1'b0;
    neuron_outvalid = '0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // run_start with nothing loaded
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    check("noload_err", 64'(err), 64'd1);
    check("noload_busy", 64'(busy), 64'd0);
    tick();
    check("noload_err_pulse", 64'(err), 64'd0);
    check("noload_still_idle", 64'(busy), 64'd0);
    check("noload_err_count", 64'(n_err_pulse), 64'd1);

    load_all(0, 1'b0);           // back-to-back load
    run_case(2, 0, 0, 0);        // gap before third beat, all outvalid at once
    run_case(-1, 0, 2, 5);       // outvalids on separate cycles
    run_case(-1, 1, 99, 99);     // no outvalid: drain timeout
    load_all(3, 1'b1);           // reload, load+run together, stalls

    for (int r = 0; r < 6; r++)
      run_case(-1, 2, $urandom_range(0, DM + 1), $urandom_range(0, DM + 1));

    // reset in the middle of a load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d = DW'($urandom);
      if (k < 4) sb_push(2'd0, CW'(0), d);
      cfg_send(d, 0);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    load_all(2, 1'b0);
    run_case(-1, 1, $urandom_range(0, 3), $urandom_range(0, 3));

    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
